// File: rtl/mdu_hilo.sv
`default_nettype none
// ============================================================================
// Module   : mdu_hilo
// Brief    : Multi-cycle multiply/divide unit with architectural HI/LO
//            registers and a start/busy/done handshake. The result is
//            computed when the op is issued, parked in a pending register
//            and committed to HI/LO on the last busy cycle.
//            Optional feature macro: MDU_MADD_EN (MADD/MSUB accumulate ops).
// Revision : 1.0 - initial release
// ============================================================================
module mdu_hilo #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_run   = 1'b1;

    localparam logic [2:0] c_op_mult  = 3'b000;
    localparam logic [2:0] c_op_multu = 3'b001;
    localparam logic [2:0] c_op_div   = 3'b010;
    localparam logic [2:0] c_op_divu  = 3'b011;
    localparam logic [2:0] c_op_mthi  = 3'b100;
    localparam logic [2:0] c_op_mtlo  = 3'b101;
`ifdef MDU_MADD_EN
    localparam logic [2:0] c_op_madd  = 3'b110;
    localparam logic [2:0] c_op_msub  = 3'b111;
`endif

    // The counter reads 0 in the last busy cycle, so it loads latency - 1.
    localparam logic [3:0] c_mult_load = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] c_div_load  = 4'(DIV_CYCLES - 1);

    logic [0:0]  r_state;
    logic [0:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic [63:0] r_pending;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [63:0] w_hilo;
    logic        w_is_mult;
    logic        w_is_div;
    logic        w_is_mac;
    logic        w_idle;
    logic        w_launch;
    logic        w_mthi;
    logic        w_mtlo;

    logic        w_mul_signed;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;

    logic        w_div_signed;
    logic        w_neg_a;
    logic        w_neg_b;
    logic        w_div_by_zero;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [63:0] w_result;

    assign w_hilo    = {r_hi, r_lo};
    assign w_idle    = (r_state == c_st_idle);
    assign w_is_mult = (op == c_op_mult) || (op == c_op_multu);
    assign w_is_div  = (op == c_op_div) || (op == c_op_divu);

    // One 64-bit multiplier serves MULT, MULTU and the accumulate ops;
    // only MULTU zero-extends its operands.
    assign w_mul_signed = (op != c_op_multu);
    assign w_mul_a      = {{32{w_mul_signed & a[31]}}, a};
    assign w_mul_b      = {{32{w_mul_signed & b[31]}}, b};
    assign w_prod       = w_mul_a * w_mul_b;

    // Signed divide runs on magnitudes, then fixes signs: the quotient
    // truncates toward zero and the remainder follows the dividend. This
    // also yields 0x80000000 / -1 = 0x80000000 rem 0 without special-casing.
    assign w_div_signed  = (op == c_op_div);
    assign w_neg_a       = w_div_signed & a[31];
    assign w_neg_b       = w_div_signed & b[31];
    assign w_div_by_zero = (b == 32'd0);
    assign w_mag_a       = w_neg_a ? -a : a;
    assign w_mag_b       = w_div_by_zero ? 32'd1 : (w_neg_b ? -b : b);
    assign w_uq          = w_mag_a / w_mag_b;
    assign w_ur          = w_mag_a % w_mag_b;
    assign w_quo         = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
    assign w_rem         = w_neg_a ? -w_ur : w_ur;

`ifdef MDU_MADD_EN
    logic [63:0] w_mac;
    assign w_is_mac = (op == c_op_madd) || (op == c_op_msub);
    assign w_mac    = (op == c_op_msub) ? (w_hilo - w_prod) : (w_hilo + w_prod);
`else
    assign w_is_mac = 1'b0;
`endif

    assign w_launch = start && w_idle && (w_is_mult || w_is_div || w_is_mac);
    assign w_mthi   = start && w_idle && (op == c_op_mthi);
    assign w_mtlo   = start && w_idle && (op == c_op_mtlo);

    assign busy = (r_state == c_st_run);
    assign done = busy && (r_cnt == 4'd0);
    assign hi   = r_hi;
    assign lo   = r_lo;

    // Select the value parked in the pending register at issue; a zero
    // divisor parks the current HI/LO so the commit leaves them unchanged.
    always_comb begin
        w_result = w_prod;
        case (op)
            c_op_div, c_op_divu: w_result = w_div_by_zero ? w_hilo : {w_rem, w_quo};
`ifdef MDU_MADD_EN
            c_op_madd, c_op_msub: w_result = w_mac;
`endif
            default: w_result = w_prod;
        endcase
    end

    // Next-state logic: launch on an accepted op, return when the count expires.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_launch) w_state_nxt = c_st_run;
            c_st_run:  if (r_cnt == 4'd0) w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counter, pending result and HI/LO; HI/LO only move on commit or MTxx.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= 4'd0;
            r_pending <= 64'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
        end else begin
            if (w_launch) begin
                r_cnt     <= w_is_div ? c_div_load : c_mult_load;
                r_pending <= w_result;
            end else if (busy && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (done) begin
                r_hi <= r_pending[63:32];
                r_lo <= r_pending[31:0];
            end else if (w_mthi) begin
                r_hi <= a;
            end else if (w_mtlo) begin
                r_lo <= a;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_hilo.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_hilo
// Brief    : Self-checking bench for mdu_hilo: directed vector table,
//            hand-written busy/reset sequences and random ops against an
//            arithmetic reference model. Honours MDU_MADD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_hilo;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] m_hl;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[15];

    mdu_hilo #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference arithmetic on 64-bit integers, straight from the op definitions.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [63:0] hl);
        longint sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: return 64'(sx * sy);
            3'd1: return {32'd0, x} * {32'd0, y};
            3'd2: begin
                if (y == 32'd0) return hl;
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (y == 32'd0) return hl;
                return {x % y, x / y};
            end
            3'd4: return {x, hl[31:0]};
            3'd5: return {hl[63:32], x};
`ifdef MDU_MADD_EN
            3'd6: return hl + 64'(sx * sy);
            default: return hl - 64'(sx * sy);
`else
            default: return hl;
`endif
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o);
        case (o)
            3'd0, 3'd1: return MULT_N;
            3'd2, 3'd3: return DIV_N;
`ifdef MDU_MADD_EN
            3'd6, 3'd7: return MULT_N;
`endif
            default: return 0;
        endcase
    endfunction

    // Entered and left just after a falling edge; issues one op and follows
    // it through every busy cycle to the first idle cycle.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] exp, input string nm);
        int n;
        n = lat_of(o);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= n; k++) begin
            check($sformatf("%s busy/done c%0d", nm, k), {62'd0, busy, done},
                  {62'd0, 1'b1, (k == n)});
            check($sformatf("%s hilo held c%0d", nm, k), {hi, lo}, m_hl);
            @(negedge clk);
        end
        check($sformatf("%s idle", nm), {62'd0, busy, done}, 64'd0);
        check($sformatf("%s result", nm), {hi, lo}, exp);
        m_hl = exp;
    endtask

    initial begin
        int n_done;
        logic [2:0]  ro;
        logic [31:0] rx, ry;

        vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'd2,         32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'd2,         32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,         32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{3'd3, 32'd7,        32'd2,         32'd1,        32'd3};
        vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF,  32'd0,        32'h80000000};
        vecs[5]  = '{3'd4, 32'h1234,     32'd0,         32'h1234,     32'h80000000};
        vecs[6]  = '{3'd5, 32'h5678,     32'd0,         32'h1234,     32'h5678};
        vecs[7]  = '{3'd2, 32'd5,        32'd0,         32'h1234,     32'h5678};
        vecs[8]  = '{3'd3, 32'd9,        32'd0,         32'h1234,     32'h5678};
        vecs[9]  = '{3'd4, 32'd0,        32'd0,         32'd0,        32'h5678};
        vecs[10] = '{3'd5, 32'd10,       32'd0,         32'd0,        32'd10};
`ifdef MDU_MADD_EN
        vecs[11] = '{3'd6, 32'd3,        32'd4,         32'd0,        32'd22};
        vecs[12] = '{3'd7, 32'd5,        32'd5,         32'hFFFFFFFF, 32'hFFFFFFFD};
`else
        vecs[11] = '{3'd6, 32'd3,        32'd4,         32'd0,        32'd10};
        vecs[12] = '{3'd7, 32'd5,        32'd5,         32'd0,        32'd10};
`endif
        vecs[13] = '{3'd2, 32'd7,        32'hFFFFFFFE,  32'd1,        32'hFFFFFFFD};
        vecs[14] = '{3'd0, 32'h80000000, 32'h80000000,  32'h40000000, 32'd0};

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset busy/done", {62'd0, busy, done}, 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        m_hl = 64'd0;
        @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 15; i++) begin
            check($sformatf("vec%0d model", i), model(vecs[i].op, vecs[i].a, vecs[i].b, m_hl),
                  {vecs[i].hi, vecs[i].lo});
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo},
                  $sformatf("vec%0d", i));
        end

        // Start during RUN is ignored; only the first multiply lands.
        start = 1'b1; op = 3'd0; a = 32'hFFFFFFFF; b = 32'd2;
        for (int k = 1; k <= MULT_N; k++) begin
            @(negedge clk);
            start = (k == 2);
            op = 3'd1; a = 32'd3; b = 32'd4;
            check($sformatf("ignore busy/done c%0d", k), {62'd0, busy, done},
                  {62'd0, 1'b1, (k == MULT_N)});
        end
        @(negedge clk);
        start = 1'b0;
        check("ignore idle", {62'd0, busy, done}, 64'd0);
        check("ignore result", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
        m_hl = 64'hFFFFFFFF_FFFFFFFE;

        // Back-to-back issue in the first idle cycle.
        do_op(3'd1, 32'd3, 32'd4, 64'd12, "b2b0");
        do_op(3'd3, 32'd100, 32'd7, {32'd2, 32'd14}, "b2b1");

        // Asynchronous reset in the middle of a multiply.
        do_op(3'd4, 32'hAAAA, 32'd0, {32'hAAAA, 32'd14}, "pre-rst");
        start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst busy", {63'd0, busy}, 64'd0);
        check("midrst hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hl = 64'd0;
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("postrst no activity", 64'(n_done), 64'd0);
        check("postrst hilo", {hi, lo}, 64'd0);

        // Random ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            ry = $urandom;
            case ($urandom_range(0, 7))
                0: ry = 32'd0;
                1: ry = 32'($urandom_range(1, 5));
                2: rx = 32'h80000000;
                default: ;
            endcase
            do_op(ro, rx, ry, model(ro, rx, ry, m_hl), $sformatf("rnd%0d op%0d", i, ro));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_hilo.md
# mdu_hilo

Multi-cycle multiply/divide responder with architectural HI/LO registers. It sits beside the ALU in the execute stage and answers the `start`/`busy` handshake that the pipeline controller drives: it accepts one operation and holds `busy` for the operation latency. Results are committed to HI/LO on the last busy cycle. The hazard unit uses `start | busy` to stall later HI/LO consumers in decode.

## Interface

Parameters:

- `MULT_CYCLES`, default 5: busy cycles for multiply-class ops (range 1–15).
- `DIV_CYCLES`, default 10: busy cycles for divide ops (range 1–15).

Ports (clock and reset first):

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle issue strobe from EX; `op`, `a` and `b` are valid when high.
- `op`  in  3  operation:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU
  - 100 MTHI, 101 MTLO
  - 110 MADD, 111 MSUB
- `a`  in  32  rs operand / dividend / MTxx source.
- `b`  in  32  rt operand / divisor.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse in the cycle HI/LO take the new result.
- `hi`  out  32  HI register, driven directly from the flop.
- `lo`  out  32  LO register, driven directly from the flop.

## Operation

- States:
  - IDLE: `busy` = 0.
  - RUN: `busy` = 1. A 4-bit down-counter and a 64-bit pending-result register are valid.
- IDLE → RUN on `start` with op ∈ {MULT, MULTU, DIV, DIVU, MADD*, MSUB*}.
  - The full result is computed from `a`, `b` and the current {hi, lo} and latched into the pending register.
  - The counter loads `MULT_CYCLES - 1` for multiply-class ops and `DIV_CYCLES - 1` for divides.
- RUN: the counter decrements each cycle. When it reads 0:
  - {hi, lo} ← pending, `done` = 1, next state IDLE.
- MTHI/MTLO with `start`: `hi` (or `lo`) ← `a` at that edge. `busy` stays 0, `done` stays 0, no state change.
- MULT: {hi, lo} = signed(a) × signed(b), full 64 bits. MULTU: same, unsigned.
- DIV: lo = quotient truncated toward zero, hi = remainder carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF yields lo = 0x80000000, hi = 0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (b = 0): the full busy sequence and `done` still occur, and HI/LO keep their prior values.
- MADD/MSUB: {hi, lo} ± signed(a) × signed(b), mod 2^64.
- `start` while `busy`: ignored, no state change. The controller never issues this.
- Reset, asynchronous and active-low, including mid-RUN: state IDLE, counter 0, `busy` 0, `done` 0, `hi` 0, `lo` 0, pending register 0. The in-flight operation is discarded.

## Timing

- `start` high in cycle T.
- `busy` is high in cycles T+1 … T+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
- `done` is high in cycle T+N.
- New `hi`/`lo` values are visible from cycle T+N+1, the same cycle `busy` returns to 0.
- A new `start` is accepted in cycle T+N+1 (back-to-back issue with no gap cycle).
- MTHI/MTLO issued at T are visible at T+1.
- `hi` and `lo` never change during RUN; readers see the old values until T+N+1.

## Configuration

- `MDU_MADD_EN` defined: op 110 = MADD and op 111 = MSUB, both with `MULT_CYCLES` latency, accumulating into the {hi, lo} value sampled at `start`.
- `MDU_MADD_EN` undefined: ops 110 and 111 are no-ops. `busy`, `done`, `hi` and `lo` are unaffected, and the 64-bit accumulate adder is not built.

## Test plan

- Reset mid-operation: MULT issued, `reset` low in cycle T+2 → `busy` = 0, `hi` = `lo` = 0 immediately (asynchronous); no `done` after release.
- MULT a = 0xFFFFFFFF, b = 2:
  - `busy` high for 5 cycles, `done` at T+5.
  - hi = 0xFFFFFFFF, lo = 0xFFFFFFFE at T+6.
  - MULTU with the same operands → hi = 0x00000001, lo = 0xFFFFFFFE.
- DIV a = 0xFFFFFFF9 (−7), b = 2:
  - 10 busy cycles.
  - lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - DIVU a = 7, b = 2 → lo = 3, hi = 1.
- Divide by zero: MTHI 0x1234, MTLO 0x5678, then DIV with b = 0 → 10 busy cycles, `done` pulses, hi = 0x1234, lo = 0x5678 unchanged.
- Issue during busy and back-to-back issue:
  - `start` MULTU 3×4 during RUN of an earlier MULT → ignored; only the first result lands.
  - `start` at T+N+1 → accepted, `busy` continuous.
- With `MDU_MADD_EN`:
  - hi:lo = 0:10, then MADD 3×4 → lo = 22.
  - Then MSUB 5×5 → hi = 0xFFFFFFFF, lo = 0xFFFFFFFD.
  - Without the macro, op 110 leaves hi:lo = 0:10 and `busy` stays 0.
